i2c_master: RTL and testbench

I2C_MASTER -- requirements
Module: i2c_master

---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_qtick.sv | 20 ++
 rtl/i2c_master.sv | 132 +++++++++++++
 tb/tb_i2c_master.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding, direction and ACK level constants for the I2C master
package i2c_pkg;
    typedef enum logic [3:0] {
        IDLE, START, ADDR, ACK_A, REG, ACK_R, RSTART, ADDR_R,
        ACK_AR, WDATA, ACK_W, RDATA, MNACK, STOP
    } state_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;
    localparam logic ACK      = 1'b0;
    localparam logic NACK     = 1'b1;

    function automatic logic is_ack(input state_t s);
        return s == ACK_A || s == ACK_R || s == ACK_AR || s == ACK_W;
    endfunction

    function automatic logic is_tx(input state_t s);
        return s == ADDR || s == REG || s == ADDR_R || s == WDATA;
    endfunction

    function automatic state_t after_byte(input state_t s);
        return s == ADDR ? ACK_A : s == REG ? ACK_R : s == ADDR_R ? ACK_AR : s == WDATA ? ACK_W : MNACK;
    endfunction
endpackage

// File: rtl/i2c_qtick.sv
// i2c_qtick: quarter-period tick generator; hold freezes the count while a slave stretches SCL
module i2c_qtick #(
    parameter int QDIV = 63
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic hold,
    output logic tick
);
    logic [15:0] cnt;

    assign tick = en && !hold && cnt == 16'(QDIV);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (!en) cnt <= '0;
        else if (!hold) cnt <= tick ? '0 : cnt + 16'd1;
    end
endmodule

// File: rtl/i2c_master.sv
// i2c_master: single-register write/read I2C master with clock stretching support
import i2c_pkg::*;

module i2c_master #(
    parameter int QDIV = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe
);
    state_t     state;
    logic [1:0] q;
    logic [2:0] bits;
    logic [7:0] sh, rx, reg_q, dat_q;
    logic [6:0] dev_q;
    logic       rw_q, rs, tick, scl_nx, sda_nx;

    // SCL released by us but still low means the slave is stretching
    i2c_qtick #(.QDIV(QDIV)) u_qtick (
        .clk  (clk),
        .rst  (rst),
        .en   (state != IDLE),
        .hold (!scl_oe && !scl_in),
        .tick (tick)
    );

    always_comb begin
        scl_nx = 1'b0;
        sda_nx = 1'b0;
        case (state)
            IDLE: ;
            START: begin
                scl_nx = q == 2'd3;
                sda_nx = q != 2'd0;
            end
            RSTART: scl_nx = q == 2'd0;
            STOP: begin
                scl_nx = q == 2'd0;
                sda_nx = q != 2'd3;
            end
            default: begin
                scl_nx = q == 2'd0 || q == 2'd3;
                sda_nx = is_tx(state) && !sh[7];
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            q         <= '0;
            bits      <= '0;
            sh        <= '0;
            rx        <= '0;
            rs        <= 1'b0;
            rw_q      <= RW_WRITE;
            dev_q     <= '0;
            reg_q     <= '0;
            dat_q     <= '0;
            rd_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ack_error <= 1'b0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
        end else begin
            done   <= 1'b0;
            scl_oe <= scl_nx;
            sda_oe <= sda_nx;
            if (state == IDLE) begin
                if (start) begin
                    {rw_q, dev_q, reg_q, dat_q} <= {rw, dev_addr, reg_addr, wr_data};
                    state     <= START;
                    busy      <= 1'b1;
                    ack_error <= 1'b0;
                    q         <= '0;
                    bits      <= '0;
                    rs        <= 1'b0;
                end
            end else if (tick) begin
                q <= q + 2'd1;
                if (q == 2'd1 && is_ack(state) && sda_in == NACK) ack_error <= 1'b1;
                if (q == 2'd1 && state == RDATA) rx <= {rx[6:0], sda_in};
                if (q == 2'd3) begin
                    case (state)
                        START: begin
                            state <= rs ? ADDR_R : ADDR;
                            sh    <= {dev_q, rs ? RW_READ : RW_WRITE};
                        end
                        ADDR, REG, ADDR_R, WDATA, RDATA: begin
                            bits <= bits + 3'd1;
                            sh   <= {sh[6:0], 1'b0};
                            if (bits == 3'd7) state <= after_byte(state);
                        end
                        ACK_A: begin
                            state <= ack_error ? STOP : REG;
                            sh    <= reg_q;
                        end
                        ACK_R: begin
                            state <= ack_error ? STOP : rw_q == RW_READ ? RSTART : WDATA;
                            sh    <= dat_q;
                        end
                        ACK_AR: state <= ack_error ? STOP : RDATA;
                        RSTART: begin
                            state <= START;
                            rs    <= 1'b1;
                        end
                        STOP: begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            if (rw_q == RW_READ && !ack_error) rd_data <= rx;
                        end
                        default: state <= STOP;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: randomized scoreboard bench with a behavioural I2C slave on the bus
module tb_i2c_master;
    localparam int QDIV = 3;
    localparam int QL = QDIV + 1;
    localparam logic [6:0] SADDR = 7'h2A;
    localparam int S_TOK = 256, P_TOK = 257, M_NACK = 258, M_ACK = 259;

    logic clk = 0, rst = 1, start = 0, rw = 0;
    logic [6:0] dev_addr = 0;
    logic [7:0] reg_addr = 0, wr_data = 0;
    logic [7:0] rd_data;
    logic busy, done, ack_error, scl_oe, sda_oe, scl_in, sda_in;
    logic sl_scl = 0, sl_sda = 0;

    assign scl_in = !(scl_oe || sl_scl);
    assign sda_in = !(sda_oe || sl_sda);

    i2c_master #(.QDIV(QDIV)) dut (
        .clk(clk), .rst(rst), .start(start), .rw(rw), .dev_addr(dev_addr),
        .reg_addr(reg_addr), .wr_data(wr_data), .rd_data(rd_data), .busy(busy),
        .done(done), .ack_error(ack_error), .scl_in(scl_in), .sda_in(sda_in),
        .scl_oe(scl_oe), .sda_oe(sda_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        logic err;
        logic [7:0] rd;
        int quarters;
        bit stretch;
    } exp_t;

    exp_t sb[$];
    int eb[$];
    int bus_log[$];
    logic [7:0] smem[256];
    logic [7:0] mmem[256];
    logic [7:0] rd_model = 0;
    bit present = 1, stretch_en = 0;
    int tests = 0, fails = 0, ndone = 0, bcnt = 0, hcnt = 0, min_high = 1 << 30;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural slave: decodes START/STOP/bits from line levels, ACKs its address, serves a register file
    int s_cnt = 0, s_bidx = 0, stretch_left = 0;
    logic [7:0] s_sh = 0, tx = 0, ptr = 0;
    bit active = 0, matched = 0, rd_dir = 0, tx_mode = 0;
    logic ps = 1, pd = 1;
    initial forever begin
        logic s, d;
        @(negedge clk);
        s = scl_in;
        d = sda_in;
        if (stretch_left > 0) begin
            stretch_left--;
            if (stretch_left == 0) sl_scl = 0;
        end
        if (ps && s && pd && !d) begin
            bus_log.push_back(S_TOK);
            s_cnt = 0; s_bidx = 0; tx_mode = 0; active = 1; matched = 0;
        end else if (ps && s && !pd && d) begin
            if (active) bus_log.push_back(P_TOK);
            active = 0; tx_mode = 0; sl_sda = 0;
        end else if (active && !ps && s) begin
            if (s_cnt < 8) begin
                s_sh = {s_sh[6:0], d};
                s_cnt++;
                if (s_cnt == 8) begin
                    bus_log.push_back(int'(s_sh));
                    if (s_bidx == 0) begin
                        matched = present && s_sh[7:1] == SADDR;
                        rd_dir = s_sh[0];
                    end else if (!rd_dir && matched) begin
                        if (s_bidx == 1) ptr = s_sh;
                        else begin smem[ptr] = s_sh; ptr++; end
                    end
                    s_bidx++;
                end
            end else begin
                s_cnt = 9;
                if (tx_mode) begin
                    bus_log.push_back(d ? M_NACK : M_ACK);
                    if (d) tx_mode = 0;
                end
            end
        end else if (active && ps && !s) begin
            if (s_cnt == 8) begin
                sl_sda = !tx_mode && matched;
                if (stretch_en && s_bidx == 2 && !rd_dir && matched) begin
                    sl_scl = 1; stretch_left = 200; stretch_en = 0;
                end
            end else if (s_cnt == 9) begin
                s_cnt = 0;
                if (s_bidx == 1 && rd_dir && matched) begin tx_mode = 1; tx = smem[ptr]; end
                sl_sda = tx_mode && !tx[7];
            end else sl_sda = tx_mode && !tx[3'(7 - s_cnt)];
        end
        ps = s;
        pd = d;
    end

    // Monitor: measures busy length and SCL high time, checks against the scoreboard on every done
    initial forever begin
        @(negedge clk);
        if (busy) bcnt++;
        if (scl_in) hcnt++;
        else begin
            if (hcnt > 0 && busy && hcnt < min_high) min_high = hcnt;
            hcnt = 0;
        end
        if (done) begin
            ndone++;
            if (sb.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_done: no transaction pending");
            end else begin
                exp_t e;
                string g, x;
                bit ok;
                int nom;
                e = sb.pop_front();
                ok = bus_log.size() == e.n;
                g = ""; x = "";
                for (int i = 0; i < e.n; i++) begin
                    int v;
                    v = eb.pop_front();
                    x = {x, $sformatf("%0h ", v)};
                    if (i >= bus_log.size() || bus_log[i] != v) ok = 0;
                end
                for (int i = 0; i < bus_log.size() && i < 20; i++) g = {g, $sformatf("%0h ", bus_log[i])};
                tests++;
                if (!ok) begin
                    fails++;
                    $display("FAIL bus_seq: got [%s] expected [%s]", g, x);
                end
                check("ack_error", ack_error, e.err);
                check("rd_data", rd_data, e.rd);
                check("busy_at_done", busy, 0);
                check("lines_at_done", {scl_oe, sda_oe}, 0);
                nom = e.quarters * QL;
                if (!e.stretch) check("busy_len", bcnt, nom);
                else begin
                    tests++;
                    if (bcnt < nom + 150 || bcnt > nom + 200) begin
                        fails++;
                        $display("FAIL busy_len_stretch: got %0d expected %0d..%0d", bcnt, nom + 150, nom + 200);
                    end
                end
                tests++;
                if (min_high < 2 * QL) begin
                    fails++;
                    $display("FAIL scl_high: got %0d expected >= %0d", min_high, 2 * QL);
                end
            end
            bus_log.delete();
            bcnt = 0;
            min_high = 1 << 30;
        end
    end

    // Reference model: bus tokens and transaction length in quarters from the protocol rules
    task automatic issue(input logic r, input logic [6:0] da, input logic [7:0] ra, input logic [7:0] wd, input bit st);
        exp_t e;
        int b[$];
        bit m;
        m = present && da == SADDR;
        e.stretch = st;
        b = {S_TOK, int'({da, 1'b0})};
        if (!m) begin
            b.push_back(P_TOK);
            e.err = 1;
            e.quarters = 4 * (1 + 9 + 1);
        end else if (!r) begin
            b = {b, int'(ra), int'(wd), P_TOK};
            mmem[ra] = wd;
            e.err = 0;
            e.quarters = 4 * (1 + 3 * 9 + 1);
        end else begin
            b = {b, int'(ra), S_TOK, int'({da, 1'b1}), int'(mmem[ra]), M_NACK, P_TOK};
            rd_model = mmem[ra];
            e.err = 0;
            e.quarters = 4 * (1 + 2 * 9 + 1 + 1 + 9 + 9 + 1);
        end
        e.rd = rd_model;
        e.n = b.size();
        foreach (b[i]) eb.push_back(b[i]);
        sb.push_back(e);
        stretch_en = st;
        rw = r; dev_addr = da; reg_addr = ra; wr_data = wd; start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(input string name);
        int target, k;
        target = ndone + 1;
        k = 0;
        while (ndone < target && k < 20000) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (ndone < target) begin
            fails++;
            $display("FAIL %s_timeout: got no done after %0d cycles, required done", name, k);
        end
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k;
        logic [7:0] old;
        for (int i = 0; i < 256; i++) begin
            smem[i] = 8'($urandom);
            mmem[i] = smem[i];
        end
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack_error", ack_error, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_scl_oe", scl_oe, 0);
        check("rst_sda_oe", sda_oe, 0);
        rst = 0;
        repeat (3) @(negedge clk);

        issue(1'b0, 7'h2A, 8'h03, 8'hA5, 0);
        wait_done("write");

        smem[8'h05] = 8'h5C;
        mmem[8'h05] = 8'h5C;
        issue(1'b1, 7'h2A, 8'h05, 8'h00, 0);
        wait_done("read");
        check("read_value", rd_data, 8'h5C);

        present = 0;
        issue(1'b1, 7'h2A, 8'h07, 8'h00, 0);
        wait_done("no_slave");
        present = 1;

        issue(1'b0, 7'h2A, 8'h10, 8'h3C, 1);
        wait_done("stretch");

        old = mmem[8'h44];
        issue(1'b0, 7'h2A, 8'h44, 8'h99, 0);
        k = 0;
        while (!(s_bidx == 1 && s_cnt == 3) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (k >= 5000) begin
            fails++;
            $display("FAIL reg_bit4_timeout: got no 4th reg bit, required one");
        end
        repeat (4 * QL + 1) @(negedge clk);
        rst = 1;
        #1;
        check("midrst_scl_oe", scl_oe, 0);
        check("midrst_sda_oe", sda_oe, 0);
        check("midrst_busy", busy, 0);
        check("midrst_rd_data", rd_data, 0);
        void'(sb.pop_back());
        for (int i = 0; i < 5; i++) void'(eb.pop_back());
        mmem[8'h44] = old;
        rd_model = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);
        bus_log.delete();
        bcnt = 0;
        min_high = 1 << 30;
        issue(1'b0, 7'h2A, 8'h44, 8'h77, 0);
        wait_done("write_after_rst");
        issue(1'b1, 7'h2A, 8'h44, 8'h00, 0);
        wait_done("read_after_rst");

        issue(1'b0, 7'h2A, 8'h21, 8'h5A, 0);
        repeat (100) @(negedge clk);
        rw = 1; dev_addr = 7'h11; reg_addr = 8'hEE; wr_data = 8'h00; start = 1;
        @(negedge clk);
        start = 0;
        wait_done("busy_start");
        n = ndone;
        repeat (60) @(negedge clk);
        check("no_queue_busy", busy, 0);
        check("no_queue_done", ndone, n);

        for (int i = 0; i < 12; i++) begin
            logic r;
            logic [6:0] da;
            r = 1'($urandom_range(0, 1));
            da = $urandom_range(0, 3) == 0 ? 7'($urandom) : SADDR;
            present = $urandom_range(0, 5) != 0;
            issue(r, da, 8'($urandom), 8'($urandom), 0);
            wait_done("random");
        end
        present = 1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
